b_viterbi_322: RTL and testbench
================================

B_VITERBI_322 -- requirements
Module: b_viterbi_322

Interface
REQ-001 SHALL have parameter N, default 3, code-symbol width.
REQ-002 SHALL have parameter K, default 2, decoded bits per symbol.
REQ-003 SHALL have parameter DEPTH, default 10, survivor-memory columns (traceback depth).
REQ-004 SHALL have parameter MW, default 6, path-metric width.
REQ-005 SHALL have parameter SYNC_TH, default 4, sync-error threshold.
REQ-006 clock  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-008 Rx  in  N  received hard-decision code symbol.
REQ-009 seq_ready  in  1  input-symbol-available qualifier.
REQ-010 Dx  out  K  decoded bits, valid when oe=1.
REQ-011 oe  out  1  one-cycle output-valid strobe.
REQ-012 sync_error  out  1  loss-of-sync flag.

Function
REQ-013 Code SHALL be an 8-state rate-2/3 code; state S={s2,s1,s0}; input (u1,u0) gives next state {u1,u0,s1} and output {v2,v1,v0}={u1^s1, u0^s2^s0, u1^u0^s0}.
REQ-014 Each state SHALL have 4 predecessors {p1,S[0],p0}; the 2-bit survivor label is {p1,p0} (backward label).
REQ-015 Branch metric SHALL be the Hamming distance (0..3) between Rx and the branch output.
REQ-016 ACS SHALL compute 4 candidates per state; the lowest wins; ties go to the lowest label {p1,p0}.
REQ-017 After each ACS, the minimum new metric d SHALL be subtracted from all 8 metrics; results saturate at 2^MW-1.
REQ-018 FSM states: LOAD, ACS, WRITE, MIN, TRACE, OUT.
REQ-019 LOAD: if seq_ready=1, register Rx and go to ACS; otherwise stay in LOAD.
REQ-020 ACS lasts 1 cycle; WRITE lasts 1 cycle.
REQ-021 WRITE: store 8 survivor labels at column write_ptr and update metrics.
REQ-022 write_ptr SHALL count 0..DEPTH-1 and wrap 9->0.
REQ-023 After WRITE, if fewer than DEPTH symbols have been written since reset, go to LOAD (3 cycles per symbol); otherwise go to MIN.
REQ-024 MIN (1 cycle): select the minimum-metric state (lowest index on tie) as start state S, and set trace_ptr to the column just written.
REQ-025 TRACE (DEPTH-1 = 9 cycles): each cycle, S <= {P[trace_ptr][S][1], S[0], P[trace_ptr][S][0]} and trace_ptr decrements modulo DEPTH.
REQ-026 OUT (1 cycle): Dx=S[2:1], oe=1, then go to LOAD; with buffer full, the symbol period is 14 cycles.
REQ-027 oe SHALL be 0 in every state except OUT; Dx SHALL hold its last value outside OUT.
REQ-028 Each Dx SHALL be the decoded input of the oldest stored symbol; the decoding delay is 9 symbols.
REQ-029 d SHALL be accumulated per symbol into an 8-bit saturating counter; every DEPTH symbols, sync_error <= (acc > SYNC_TH), then acc <= 0.
REQ-030 sync_error SHALL hold its value between window updates.
REQ-031 seq_ready is sampled only in LOAD; Rx changes in other states SHALL be ignored.

Reset
REQ-032 reset=0 SHALL asynchronously clear FSM to LOAD, write_ptr=0, trace_ptr=0, symbol count=0, acc=0, window count=0, Dx=0, oe=0, sync_error=0.
REQ-033 Reset SHALL set metric(state 0)=0 and metrics of states 1..7 = 16.
REQ-034 Survivor memory SHALL NOT require reset.
REQ-035 Reset asserted mid-TRACE or mid-OUT SHALL abort at once with no oe pulse.

Verification
REQ-036 Reset, then reset=1 with seq_ready=0 -> oe=0, Dx=00, sync_error=0 indefinitely.
REQ-037 seq_ready=1, Rx=000 held -> first oe on cycle 41 after reset release, then every 14 cycles; Dx=00; sync_error=0.
REQ-038 Encode input pairs 01,10,11,00,... from state 0 and feed them error-free -> Dx reproduces that sequence in order from the first oe; sync_error=0.
REQ-039 Same stream with one bit flipped in symbol 3 -> identical Dx sequence (error corrected).
REQ-040 Stream of symbols at Hamming distance >=1 from every branch (e.g. 10 random uncoded symbols) -> acc > 4, so sync_error=1 after the window.
REQ-041 reset=0 during TRACE -> oe stays 0; after release, first oe comes 41 cycles later.

Source files
------------

// File: rtl/b_viterbi_322.sv
// b_viterbi_322 -- hard-decision Viterbi decoder for an 8-state rate-2/3 code.
//
// Encoder being decoded: state S={s2,s1,s0}. An input pair (u1,u0) moves the
// encoder to {u1,u0,s1} and emits {u1^s1, u0^s2^s0, u1^u0^s0}. The decoder
// keeps 8 path metrics and a DEPTH-column survivor memory. Each symbol takes
// LOAD->ACS->WRITE. Once the memory is full it then runs MIN->TRACE->OUT to
// release the input pair of the oldest stored symbol.
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst_n       asynchronous active-low reset
//   i_rx          received hard-decision code symbol (sampled in LOAD only)
//   i_seq_ready   symbol-available qualifier (sampled in LOAD only)
//   o_dx          decoded input pair; updated on entry to OUT, held otherwise
//   o_oe          one-cycle strobe, high only in OUT
//   o_sync_error  set when the metric growth over a DEPTH-symbol window
//                 exceeds SYNC_TH; re-evaluated once per window
module b_viterbi_322 #(
  parameter int N       = 3,
  parameter int K       = 2,
  parameter int DEPTH   = 10,
  parameter int MW      = 6,
  parameter int SYNC_TH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_rx,
  input  logic         i_seq_ready,
  output logic [K-1:0] o_dx,
  output logic         o_oe,
  output logic         o_sync_error
);

  localparam int NS = 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [MW:0] MMAX = {1'b0, {MW{1'b1}}};

  typedef enum logic [2:0] {S_LOAD, S_ACS, S_WRITE, S_MIN, S_TRACE, S_OUT} state_t;

  state_t        r_state, w_next;
  logic [N-1:0]  r_rx;
  logic [MW-1:0] r_metric     [NS];
  logic [MW-1:0] r_new_metric [NS];
  logic [1:0]    r_lab        [NS];
  logic [MW:0]   r_d;
  logic [1:0]    r_surv       [DEPTH][NS];
  logic [PW-1:0] r_wptr, r_tptr, r_tcnt, r_wcnt;
  logic [CW-1:0] r_scnt;
  logic [2:0]    r_s;
  logic [7:0]    r_acc;
  logic [K-1:0]  r_dx;
  logic          r_sync;

  logic [MW:0]   w_best [NS];
  logic [1:0]    w_lab  [NS];
  logic [MW-1:0] w_norm [NS];
  logic [MW:0]   w_d;
  logic [2:0]    w_min_state;
  logic [2:0]    w_trace_s;
  logic [1:0]    w_tlab;
  logic [7:0]    w_acc_sum;
  logic [8:0]    w_acc_raw;

  // Output of the branch from predecessor {l1,t0,l0} into state t.
  function automatic logic [2:0] branch_out(input logic [2:0] t, input logic [1:0] l);
    return {t[2] ^ t[0], t[1] ^ l[1] ^ l[0], t[2] ^ t[1] ^ l[0]};
  endfunction

  function automatic logic [1:0] hamming3(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] x;
    x = a ^ b;
    return {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
  endfunction

  // Add-compare-select over the backward trellis, then normalisation.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    logic [MW:0] cand;
    logic [2:0]  ts;
    logic [1:0]  ls;
    logic [MW:0] diff;
    cand = '0;
    ts   = '0;
    ls   = '0;
    diff = '0;
    w_d  = '1;
    for (int t = 0; t < NS; t++) begin
      ts       = 3'(t);
      w_best[t] = '1;
      w_lab[t]  = 2'd0;
      // Labels visited in ascending order with a strict compare: ties keep the lower label.
      for (int l = 0; l < 4; l++) begin
        ls   = 2'(l);
        cand = {1'b0, r_metric[{ls[1], ts[0], ls[0]}]}
             + {{(MW-1){1'b0}}, hamming3(r_rx, branch_out(ts, ls))};
        if (cand < w_best[t]) begin
          w_best[t] = cand;
          w_lab[t]  = ls;
        end
      end
      if (w_best[t] < w_d) w_d = w_best[t];
    end
    for (int t = 0; t < NS; t++) begin
      diff      = w_best[t] - w_d;
      w_norm[t] = (diff > MMAX) ? MMAX[MW-1:0] : diff[MW-1:0];
    end
  end

  // Lowest-index state with the smallest metric starts the traceback.
  always_comb begin
    w_min_state = 3'd0;
    for (int t = 1; t < NS; t++)
      if (r_metric[t] < r_metric[w_min_state]) w_min_state = 3'(t);
  end

  assign w_tlab    = r_surv[r_tptr][r_s];
  assign w_trace_s = {w_tlab[1], r_s[0], w_tlab[0]};
  assign w_acc_raw = {1'b0, r_acc} + 9'(r_d);
  assign w_acc_sum = w_acc_raw[8] ? 8'hFF : w_acc_raw[7:0];

  // NOTE: sequential state always uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_LOAD;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_oe   = 1'b0;
    unique case (r_state)
      S_LOAD:  if (i_seq_ready) w_next = S_ACS;
      S_ACS:   w_next = S_WRITE;
      S_WRITE: w_next = (r_scnt >= CW'(DEPTH - 1)) ? S_MIN : S_LOAD;
      S_MIN:   w_next = S_TRACE;
      S_TRACE: if (r_tcnt == PW'(DEPTH - 2)) w_next = S_OUT;
      S_OUT: begin
        o_oe   = 1'b1;
        w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx <= '0;
      for (int t = 0; t < NS; t++) begin
        r_metric[t]     <= (t == 0) ? '0 : MW'(16);
        r_new_metric[t] <= '0;
        r_lab[t]        <= '0;
      end
      r_d    <= '0;
      r_wptr <= '0;
      r_tptr <= '0;
      r_tcnt <= '0;
      r_wcnt <= '0;
      r_scnt <= '0;
      r_s    <= '0;
      r_acc  <= '0;
      r_dx   <= '0;
      r_sync <= 1'b0;
    end else begin
      unique case (r_state)
        S_LOAD: if (i_seq_ready) r_rx <= i_rx;
        S_ACS: begin
          r_new_metric <= w_norm;
          r_lab        <= w_lab;
          r_d          <= w_d;
        end
        S_WRITE: begin
          r_metric <= r_new_metric;
          r_wptr   <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
          if (r_scnt < CW'(DEPTH)) r_scnt <= r_scnt + 1'b1;
          // The window closes on its DEPTH-th symbol, including that symbol's d.
          if (r_wcnt == PW'(DEPTH - 1)) begin
            r_sync <= (w_acc_sum > 8'(SYNC_TH));
            r_acc  <= '0;
            r_wcnt <= '0;
          end else begin
            r_acc  <= w_acc_sum;
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_MIN: begin
          r_s    <= w_min_state;
          r_tptr <= (r_wptr == '0) ? PW'(DEPTH - 1) : r_wptr - 1'b1;
          r_tcnt <= '0;
        end
        S_TRACE: begin
          r_s    <= w_trace_s;
          r_tptr <= (r_tptr == '0) ? PW'(DEPTH - 1) : r_tptr - 1'b1;
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt == PW'(DEPTH - 2)) r_dx <= w_trace_s[2:1];
        end
        default: ;
      endcase
    end
  end

  // NOTE: survivor memory is never read before being written, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (r_state == S_WRITE)
      for (int t = 0; t < NS; t++) r_surv[r_wptr][t] <= r_lab[t];
  end

  assign o_dx         = r_dx;
  assign o_sync_error = r_sync;

endmodule

// File: tb/tb_b_viterbi_322.sv
// Testbench for b_viterbi_322: randomized and directed symbol streams checked
// against a forward-trellis Viterbi reference model with unbounded history.
module tb_b_viterbi_322;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx = 3'd0;
  logic       seq = 1'b0;
  logic [1:0] dx;
  logic       oe;
  logic       sync_err;

  b_viterbi_322 dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .i_seq_ready  (seq),
    .o_dx         (dx),
    .o_oe         (oe),
    .o_sync_error (sync_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m[8];
  logic [1:0] surv[256][8];
  int         nsym, acc, wcnt;
  logic       m_sync;
  logic [1:0] m_dx;

  function automatic logic [2:0] enc_out(input logic [2:0] s, input logic [1:0] u);
    return {u[1] ^ s[1], u[0] ^ s[2] ^ s[0], u[1] ^ u[0] ^ s[0]};
  endfunction

  function automatic logic [2:0] enc_next(input logic [2:0] s, input logic [1:0] u);
    return {u[1], u[0], s[1]};
  endfunction

  task automatic model_reset();
    m[0] = 0;
    for (int s = 1; s < 8; s++) m[s] = 16;
    nsym = 0; acc = 0; wcnt = 0; m_sync = 1'b0; m_dx = 2'b00;
  endtask

  // Walk every (state, input) branch forward; each destination keeps the best.
  task automatic model_symbol(input logic [2:0] r);
    int best[8];
    logic [1:0] lab[8];
    logic [2:0] ps, ns;
    logic [1:0] us, l;
    int c, d;
    for (int s = 0; s < 8; s++) begin best[s] = 1 << 30; lab[s] = 2'b00; end
    for (int p = 0; p < 8; p++) begin
      for (int u = 0; u < 4; u++) begin
        ps = 3'(p); us = 2'(u);
        ns = enc_next(ps, us);
        c  = m[p] + $countones(enc_out(ps, us) ^ r);
        l  = {ps[2], ps[0]};
        if (c < best[ns] || (c == best[ns] && l < lab[ns])) begin
          best[ns] = c;
          lab[ns]  = l;
        end
      end
    end
    d = best[0];
    for (int s = 1; s < 8; s++) if (best[s] < d) d = best[s];
    nsym++;
    for (int s = 0; s < 8; s++) begin
      m[s] = (best[s] - d > 63) ? 63 : best[s] - d;
      surv[nsym][s] = lab[s];
    end
    acc = (acc + d > 255) ? 255 : acc + d;
    wcnt++;
    if (wcnt == 10) begin
      m_sync = (acc > 4);
      acc = 0;
      wcnt = 0;
    end
  endtask

  task automatic model_trace();
    logic [2:0] s;
    logic [1:0] lb;
    int bi;
    bi = 0;
    for (int k = 1; k < 8; k++) if (m[k] < m[bi]) bi = k;
    s = 3'(bi);
    for (int k = 0; k < 9; k++) begin
      lb = surv[nsym - k][s];
      s  = {lb[1], s[0], lb[0]};
    end
    m_dx = s[2:1];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic exp_oe);
    @(posedge clk);
    #1;
    edges++;
    check("oe", oe, exp_oe);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    edges = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    seq = 1'b0;
    #1;
    check("rst_oe", oe, 1'b0);
    check("rst_dx", dx, 2'b00);
    check("rst_sync", sync_err, 1'b0);
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // mode 0: all-zero, 1: 01,10,11,00 pattern, 2: pattern with symbol 3 corrupted,
  // 3: random uncoded symbols, 4: random inputs with sparse random bit errors.
  task automatic run_stream(input int n, input int mode, input int max_stall);
    logic [2:0] syms[64];
    logic [1:0] us[64];
    logic [1:0] pat[4];
    logic [2:0] st;
    int nout, stall;
    bit first;
    pat = '{2'b01, 2'b10, 2'b11, 2'b00};
    st = 3'd0;
    for (int i = 1; i <= n; i++) begin
      case (mode)
        0:       us[i] = 2'b00;
        1, 2:    us[i] = pat[(i - 1) % 4];
        default: us[i] = 2'($urandom);
      endcase
      syms[i] = enc_out(st, us[i]);
      st = enc_next(st, us[i]);
      if (mode == 2 && i == 3) syms[i] = syms[i] ^ 3'b010;
      if (mode == 3) syms[i] = 3'($urandom);
      if (mode == 4 && $urandom_range(7) == 0) syms[i] = syms[i] ^ 3'(1 << $urandom_range(2));
    end
    nout = 0;
    first = 1'b1;
    for (int i = 1; i <= n; i++) begin
      stall = (max_stall > 0) ? $urandom_range(max_stall) : 0;
      repeat (stall) begin
        seq = 1'b0;
        rx  = 3'($urandom);
        step(1'b0);
      end
      seq = 1'b1;
      rx  = syms[i];
      model_symbol(syms[i]);
      step(1'b0);
      seq = 1'($urandom);
      rx  = 3'($urandom);
      if (i < 10) begin
        step(1'b0);
        step(1'b0);
      end else begin
        repeat (11) step(1'b0);
        step(1'b1);
        model_trace();
        nout++;
        check("dx", dx, m_dx);
        if (first) begin
          first = 1'b0;
          if (max_stall == 0) check("first_oe_cycle", edges + 1, 41);
        end
        if (mode == 1 || mode == 2) check("dx_vs_input", dx, us[nout]);
        step(1'b0);
      end
      check("dx_hold", dx, m_dx);
      check("sync", sync_err, m_sync);
    end
    seq = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("por_oe", oe, 1'b0);
    check("por_dx", dx, 2'b00);
    check("por_sync", sync_err, 1'b0);
    release_reset();

    // Idle with no symbols offered: nothing may come out.
    for (int c = 0; c < 40; c++) begin
      seq = 1'b0;
      rx  = 3'($urandom);
      step(1'b0);
      check("idle_dx", dx, 2'b00);
      check("idle_sync", sync_err, 1'b0);
    end

    apply_reset(); run_stream(30, 0, 0);
    apply_reset(); run_stream(24, 1, 0);
    apply_reset(); run_stream(24, 2, 0);
    apply_reset(); run_stream(30, 3, 3);
    apply_reset(); run_stream(40, 4, 3);

    // Abort in the middle of a traceback.
    apply_reset();
    run_stream(11, 0, 0);
    seq = 1'b1;
    rx  = 3'd0;
    step(1'b0);
    seq = 1'b0;
    repeat (6) step(1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_oe", oe, 1'b0);
    check("abort_dx", dx, 2'b00);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_hold_oe", oe, 1'b0);
    end
    release_reset();
    run_stream(12, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
